// File: rtl/phase_word_loader.sv
// phase_word_loader: framed byte loader for the phase adder's frequency
// word and phase offset, committed atomically with one-cycle strobes.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_byte_valid, i_byte  byte stream in
//   o_byte_ready          low in reset and during the commit cycle
//   o_msb/o_isb/o_lsb     committed frequency word [23:16]/[15:8]/[7:0]
//   o_phaseadd            committed 12-bit phase offset
//   o_freq_update         one-cycle pulse when the frequency word changes
//   o_phaseadjusten       one-cycle pulse when the phase offset changes
//   o_err, o_err_code     abort pulse; code 01 cmd, 10 timeout, 11 phase
module phase_word_loader #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_byte_ready,
  output logic [7:0]  o_msb,
  output logic [7:0]  o_isb,
  output logic [7:0]  o_lsb,
  output logic [11:0] o_phaseadd,
  output logic        o_freq_update,
  output logic        o_phaseadjusten,
  output logic        o_err,
  output logic [1:0]  o_err_code
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FREQ,
    S_PHASE,
    S_COMMIT
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          do_freq_q, do_freq_d;
  logic          do_ph_q, do_ph_d;
  logic [7:0]    sh_msb_q, sh_msb_d;
  logic [7:0]    sh_isb_q, sh_isb_d;
  logic [7:0]    sh_lsb_q, sh_lsb_d;
  logic [11:0]   sh_ph_q, sh_ph_d;
  logic [7:0]    msb_q, msb_d;
  logic [7:0]    isb_q, isb_d;
  logic [7:0]    lsb_q, lsb_d;
  logic [11:0]   ph_q, ph_d;
  logic          fu_q, fu_d;
  logic          pa_q, pa_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic          xfer;

  assign o_byte_ready    = ~i_rst & (state_q != S_COMMIT);
  assign xfer            = i_byte_valid & o_byte_ready;
  assign o_msb           = msb_q;
  assign o_isb           = isb_q;
  assign o_lsb           = lsb_q;
  assign o_phaseadd      = ph_q;
  assign o_freq_update   = fu_q;
  assign o_phaseadjusten = pa_q;
  assign o_err           = err_q;
  assign o_err_code      = code_q;

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    tcnt_d    = tcnt_q;
    do_freq_d = do_freq_q;
    do_ph_d   = do_ph_q;
    sh_msb_d  = sh_msb_q;
    sh_isb_d  = sh_isb_q;
    sh_lsb_d  = sh_lsb_q;
    sh_ph_d   = sh_ph_q;
    msb_d     = msb_q;
    isb_d     = isb_q;
    lsb_d     = lsb_q;
    ph_d      = ph_q;
    fu_d      = 1'b0;
    pa_d      = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    unique case (state_q)
      S_IDLE: begin
        tcnt_d = '0;
        bcnt_d = '0;
        if (xfer) begin
          unique case (i_byte)
            8'hA1: begin
              do_freq_d = 1'b1;
              do_ph_d   = 1'b0;
              state_d   = S_FREQ;
            end
            8'hA2: begin
              do_freq_d = 1'b0;
              do_ph_d   = 1'b1;
              state_d   = S_PHASE;
            end
            8'hA3: begin
              do_freq_d = 1'b1;
              do_ph_d   = 1'b1;
              state_d   = S_FREQ;
            end
            default: begin
              err_d  = 1'b1;
              code_d = 2'b01;
            end
          endcase
        end
      end
      S_FREQ: begin
        if (xfer) begin
          tcnt_d = '0;
          if (bcnt_q == 2'd0) sh_msb_d = i_byte;
          if (bcnt_q == 2'd1) sh_isb_d = i_byte;
          if (bcnt_q == 2'd2) begin
            sh_lsb_d = i_byte;
            bcnt_d   = '0;
            state_d  = do_ph_q ? S_PHASE : S_COMMIT;
          end else begin
            bcnt_d = bcnt_q + 2'd1;
          end
        end else if (tcnt_q == TMAX) begin
          tcnt_d  = '0;
          bcnt_d  = '0;
          state_d = S_IDLE;
          err_d   = 1'b1;
          code_d  = 2'b10;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_PHASE: begin
        if (xfer) begin
          tcnt_d = '0;
          if (bcnt_q == 2'd0) begin
            if (i_byte[7:4] != 4'h0) begin
              state_d = S_IDLE;
              err_d   = 1'b1;
              code_d  = 2'b11;
            end else begin
              sh_ph_d[11:8] = i_byte[3:0];
              bcnt_d        = 2'd1;
            end
          end else begin
            sh_ph_d[7:0] = i_byte;
            bcnt_d       = '0;
            state_d      = S_COMMIT;
          end
        end else if (tcnt_q == TMAX) begin
          tcnt_d  = '0;
          bcnt_d  = '0;
          state_d = S_IDLE;
          err_d   = 1'b1;
          code_d  = 2'b10;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_COMMIT: begin
        if (do_freq_q) begin
          msb_d = sh_msb_q;
          isb_d = sh_isb_q;
          lsb_d = sh_lsb_q;
          fu_d  = 1'b1;
        end
        if (do_ph_q) begin
          ph_d = sh_ph_q;
          pa_d = 1'b1;
        end
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      bcnt_q    <= '0;
      tcnt_q    <= '0;
      do_freq_q <= 1'b0;
      do_ph_q   <= 1'b0;
      sh_msb_q  <= '0;
      sh_isb_q  <= '0;
      sh_lsb_q  <= '0;
      sh_ph_q   <= '0;
      msb_q     <= '0;
      isb_q     <= '0;
      lsb_q     <= '0;
      ph_q      <= '0;
      fu_q      <= 1'b0;
      pa_q      <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      tcnt_q    <= tcnt_d;
      do_freq_q <= do_freq_d;
      do_ph_q   <= do_ph_d;
      sh_msb_q  <= sh_msb_d;
      sh_isb_q  <= sh_isb_d;
      sh_lsb_q  <= sh_lsb_d;
      sh_ph_q   <= sh_ph_d;
      msb_q     <= msb_d;
      isb_q     <= isb_d;
      lsb_q     <= lsb_d;
      ph_q      <= ph_d;
      fu_q      <= fu_d;
      pa_q      <= pa_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

endmodule

// File: tb/tb_phase_word_loader.sv
// tb_phase_word_loader: directed test-plan sequences plus random frames,
// each cycle compared against a frame-level reference model.
module tb_phase_word_loader;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_byte_valid = 1'b0;
  logic [7:0]  i_byte = 8'h00;
  logic        o_byte_ready;
  logic [7:0]  o_msb, o_isb, o_lsb;
  logic [11:0] o_phaseadd;
  logic        o_freq_update, o_phaseadjusten, o_err;
  logic [1:0]  o_err_code;

  int errs = 0;
  int checks = 0;

  // reference model: bytes of the open frame, commit pending, idle count
  logic [7:0]  q[$];
  bit          commit_pend = 0;
  int          idle = 0;
  logic [7:0]  e_msb = 0, e_isb = 0, e_lsb = 0;
  logic [11:0] e_ph = 0;
  logic        e_fu = 0, e_pa = 0, e_err = 0;
  logic [1:0]  e_code = 0;

  phase_word_loader #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_byte_valid(i_byte_valid),
    .i_byte(i_byte),
    .o_byte_ready(o_byte_ready),
    .o_msb(o_msb),
    .o_isb(o_isb),
    .o_lsb(o_lsb),
    .o_phaseadd(o_phaseadd),
    .o_freq_update(o_freq_update),
    .o_phaseadjusten(o_phaseadjusten),
    .o_err(o_err),
    .o_err_code(o_err_code)
  );

  always #5 clk = ~clk;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int need_of(logic [7:0] c);
    return (c == 8'hA1) ? 3 : (c == 8'hA2) ? 2 : 5;
  endfunction

  function automatic int ph0_of(logic [7:0] c);
    return (c == 8'hA2) ? 1 : (c == 8'hA3) ? 4 : -1;
  endfunction

  task automatic model(bit acc, logic [7:0] b, bit r);
    int p;
    e_fu = 0;
    e_pa = 0;
    e_err = 0;
    if (r) begin
      q.delete();
      commit_pend = 0;
      idle = 0;
      e_msb = 0; e_isb = 0; e_lsb = 0; e_ph = 0; e_code = 0;
    end else if (commit_pend) begin
      if (q[0] != 8'hA2) begin
        e_msb = q[1]; e_isb = q[2]; e_lsb = q[3];
        e_fu = 1;
      end
      if (q[0] != 8'hA1) begin
        p = ph0_of(q[0]);
        e_ph = {q[p][3:0], q[p+1]};
        e_pa = 1;
      end
      q.delete();
      commit_pend = 0;
    end else if (acc) begin
      idle = 0;
      if (q.size() == 0) begin
        if (b == 8'hA1 || b == 8'hA2 || b == 8'hA3) q.push_back(b);
        else begin e_err = 1; e_code = 2'b01; end
      end else begin
        q.push_back(b);
        if (q.size() - 1 == ph0_of(q[0]) && b[7:4] != 0) begin
          e_err = 1; e_code = 2'b11;
          q.delete();
        end else if (q.size() - 1 == need_of(q[0])) begin
          commit_pend = 1;
        end
      end
    end else if (q.size() != 0) begin
      if (idle == T - 1) begin
        e_err = 1; e_code = 2'b10;
        q.delete();
        idle = 0;
      end else idle++;
    end
  endtask

  task automatic step(bit v, logic [7:0] b, bit r);
    bit exp_rdy;
    @(negedge clk);
    i_byte_valid = v;
    i_byte = b;
    i_rst = r;
    #1;
    exp_rdy = !r && !commit_pend;
    check_eq("ready", o_byte_ready, exp_rdy);
    model(v && exp_rdy, b, r);
    @(posedge clk);
    #1;
    check_eq("msb", o_msb, e_msb);
    check_eq("isb", o_isb, e_isb);
    check_eq("lsb", o_lsb, e_lsb);
    check_eq("phase", o_phaseadd, e_ph);
    check_eq("fupd", o_freq_update, e_fu);
    check_eq("padj", o_phaseadjusten, e_pa);
    check_eq("err", o_err, e_err);
    check_eq("code", o_err_code, e_code);
  endtask

  task automatic idle_n(int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0);
  endtask

  // byte after `gap` idle cycles; held valid through backpressure
  task automatic send(logic [7:0] b, int gap);
    bit acc;
    idle_n(gap);
    for (int k = 0; k < 4; k++) begin
      acc = !commit_pend;
      step(1, b, 0);
      if (acc) break;
    end
  endtask

  task automatic send_seq(logic [7:0] bs[$], int maxgap);
    foreach (bs[i]) send(bs[i], $urandom_range(0, maxgap));
  endtask

  initial begin
    logic [7:0] fr[$];
    int kind;
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    idle_n(2);

    send_seq('{8'hA1, 8'h12, 8'h34, 8'h56}, 0);
    idle_n(3);
    send_seq('{8'hA3, 8'hAB, 8'hCD, 8'hEF, 8'h0F, 8'hFF}, 5);
    idle_n(3);
    send_seq('{8'h55}, 0);
    send_seq('{8'hA2, 8'h1F}, 0);
    send_seq('{8'hA2, 8'h03, 8'h21}, 0);
    idle_n(2);
    send_seq('{8'hA1, 8'h11}, 0);
    idle_n(20);
    send_seq('{8'hA1, 8'h01, 8'h02, 8'h03}, 0);
    idle_n(2);
    send_seq('{8'hA1, 8'h44}, 0);
    send(8'h55, T - 1);
    send(8'h66, 0);
    idle_n(2);
    send_seq('{8'hA3, 8'hAA, 8'hBB}, 0);
    step(0, 8'h00, 1);
    idle_n(2);
    send_seq('{8'hA2, 8'h00, 8'h07}, 0);
    idle_n(2);

    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 9);
      fr.delete();
      if (kind == 0) begin
        fr.push_back(8'(($urandom_range(0, 255) & 8'hFC) ^ 8'h10));
        send_seq(fr, 2);
      end else if (kind == 1) begin
        send_seq('{8'hA3, 8'($urandom), 8'($urandom)}, 2);
        step(0, 8'h00, 1);
      end else begin
        fr.push_back(8'hA1 + 8'($urandom_range(0, 2)));
        for (int i = 0; i < need_of(fr[0]); i++) begin
          fr.push_back(8'($urandom));
          if (i + 1 == ph0_of(fr[0]) && $urandom_range(0, 7) != 0)
            fr[i+1][7:4] = 4'h0;
        end
        foreach (fr[i]) begin
          if ($urandom_range(0, 15) == 0) send(fr[i], $urandom_range(T - 2, T + 1));
          else send(fr[i], $urandom_range(0, 3));
        end
      end
      idle_n($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
